demux_rr_n: RTL



---
 rtl/phy_rx_pkg.sv | 22 ++
 rtl/demux_idle_timer.sv | 42 ++++
 rtl/demux_rr_n.sv | 128 ++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared phy_rx definitions: demux FSM encoding, lane defaults,
// and a constant-safe clog2 helper.
package phy_rx_pkg;

   localparam int PHY_WIDTH   = 8;
   localparam int PHY_NUM_OUT = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FILL  = 1'b1
   } dmx_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_idle_timer.sv
// Idle cycle counter for the demux: clears, increments, saturates,
// and pulses timeout on the cycle the idle limit is reached.
module demux_idle_timer
   import phy_rx_pkg::*;
#(
   parameter int LIMIT = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic timeout_o
);

   localparam int CW = (LIMIT > 0) ? clog2(LIMIT + 1) : 1;
   localparam logic [CW-1:0] CMAX = CW'(LIMIT);
   localparam logic [CW-1:0] CFIRE = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < CMAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // LIMIT==0 disables auto-flush entirely
   assign timeout_o = (LIMIT > 0) && inc_i && (cnt_q == CFIRE);

endmodule

// File: rtl/demux_rr_n.sv
// Round-robin 1-to-NUM_OUT word demux with explicit and idle flush
// of partial groups; single clock, registered lane outputs.
module demux_rr_n
   import phy_rx_pkg::*;
#(
   parameter int WIDTH      = PHY_WIDTH,
   parameter int NUM_OUT    = PHY_NUM_OUT,
   parameter int IDLE_FLUSH = 0
) (
   input  logic                       clk_f,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       valid_in,
   input  logic                       flush,
   output logic [NUM_OUT*WIDTH-1:0]   data_out,
   output logic [NUM_OUT-1:0]         valid_out,
   output logic                       group_strobe,
   output logic [clog2(NUM_OUT)-1:0]  lane_ptr
);

   localparam int PW = clog2(NUM_OUT);
   localparam logic [PW-1:0] LAST = PW'(NUM_OUT - 1);

   dmx_state_e state_q, state_d;

   logic [PW-1:0]            ptr_q, ptr_d;
   logic [NUM_OUT-1:0]       mask_q, mask_d;
   logic [WIDTH-1:0]         stage_q [NUM_OUT];
   logic [NUM_OUT*WIDTH-1:0] data_out_q, data_out_d;
   logic [NUM_OUT-1:0]       valid_out_q, valid_out_d;
   logic                     strobe_q;

   logic [NUM_OUT-1:0] cur_bit;
   logic [NUM_OUT-1:0] eff_mask;
   logic               full_emit;
   logic               flush_emit;
   logic               emit;
   logic               timeout;
   logic               fill;
   logic               tmr_inc;
   logic               tmr_clr;

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (emit) begin
         state_d = ST_EMPTY;
      end else if (valid_in) begin
         state_d = ST_FILL;
      end
   end

   always_comb begin
      fill    = (state_q == ST_FILL);
      tmr_inc = fill && !valid_in;
      tmr_clr = !fill || valid_in || emit;
   end

   demux_idle_timer #(
      .LIMIT (IDLE_FLUSH)
   ) u_idle (
      .clk_i     (clk_f),
      .rst_i     (reset),
      .clr_i     (tmr_clr),
      .inc_i     (tmr_inc),
      .timeout_o (timeout)
   );

   // the word arriving this cycle joins the group being emitted
   always_comb begin
      cur_bit = '0;
      if (valid_in) cur_bit[ptr_q] = 1'b1;
      eff_mask   = mask_q | cur_bit;
      full_emit  = valid_in && (ptr_q == LAST);
      flush_emit = (flush || timeout) && ((mask_q != '0) || valid_in);
      emit       = full_emit || flush_emit;
   end

   always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = emit ? eff_mask : '0;
      ptr_d       = ptr_q;
      mask_d      = mask_q;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (emit && eff_mask[k]) begin
            data_out_d[k*WIDTH +: WIDTH] = cur_bit[k] ? data_in : stage_q[k];
         end
      end
      if (emit) begin
         ptr_d  = '0;
         mask_d = '0;
      end else if (valid_in) begin
         ptr_d  = ptr_q + 1'b1;
         mask_d = eff_mask;
      end
   end

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         mask_q      <= '0;
         data_out_q  <= '0;
         valid_out_q <= '0;
         strobe_q    <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) stage_q[k] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mask_q      <= mask_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
         strobe_q    <= emit;
         if (valid_in) stage_q[ptr_q] <= data_in;
      end
   end

   assign data_out     = data_out_q;
   assign valid_out    = valid_out_q;
   assign group_strobe = strobe_q;
   assign lane_ptr     = ptr_q;

endmodule
